i2s_audio_tx: RTL and testbench

- Parametrised I2S transmitter for Pocket cores, clocked by clk_74a.
- Generates MCLK, SCLK, LRCK and serial DAC data from a fractional accumulator, using one clock domain only.
- A small stereo sample FIFO with a valid/ready handshake decouples the core's sample producer from the frame timing.
- Adds mono, mute and underflow-policy modes, plus underflow reporting.

---
 rtl/i2s_audio_tx.sv | 119 +++++++++++
 tb/tb_i2s_audio_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: I2S transmitter with fractional-accumulator MCLK and a stereo sample FIFO
module i2s_audio_tx #(
  parameter int ACC_INC             = 245760,
  parameter int ACC_MOD             = 742500,
  parameter int SAMPLE_WIDTH        = 16,
  parameter int FIFO_DEPTH          = 4,
  parameter int REPEAT_ON_UNDERFLOW = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SAMPLE_WIDTH-1:0]       sample_l,
  input  logic [SAMPLE_WIDTH-1:0]       sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          mono,
  input  logic                          mute,
  input  logic                          underflow_clr,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          audio_mclk,
  output logic                          audio_lrck,
  output logic                          audio_dac
);
  localparam int AW = $clog2(ACC_MOD + ACC_INC);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = SAMPLE_WIDTH;
  localparam logic [AW-1:0] INC = AW'(ACC_INC);
  localparam logic [AW-1:0] MOD = AW'(ACC_MOD);
  logic [AW-1:0] acc_q, acc_d;
  logic mclk_q, mclk_d, lrck_q, lrck_d, dac_q, dac_d, uf_q, uf_d, rdy_q, rdy_d;
  logic [1:0] div_q, div_d;
  logic [4:0] slot_q, slot_d;
  logic [31:0] shreg_q, shreg_d, hold_q, hold_d, word_l, word_r;
  logic [SW-1:0] last_l_q, last_l_d, last_r_q, last_r_d, src_l, src_r;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [SW-1:0] mem_l [FIFO_DEPTH];
  logic [SW-1:0] mem_r [FIFO_DEPTH];
  logic wrap, mclk_rise, sclk_fall, slot_end, left_load, empty, pop, push;
  assign wrap      = acc_q >= MOD;
  assign mclk_rise = wrap && !mclk_q;
  assign sclk_fall = mclk_rise && div_q == 2'd3;
  assign slot_end  = sclk_fall && slot_q == 5'd31;
  assign left_load = slot_end && lrck_q;
  assign empty     = lvl_q == '0;
  assign pop       = left_load && !empty;
  assign push      = sample_valid && rdy_q;
  // on underflow the pair comes from zeros or the last popped pair; mono/mute apply either way
  assign src_l  = pop ? mem_l[rp_q] : (REPEAT_ON_UNDERFLOW != 0 ? last_l_q : '0);
  assign src_r  = pop ? mem_r[rp_q] : (REPEAT_ON_UNDERFLOW != 0 ? last_r_q : '0);
  assign word_l = mute ? '0 : {src_l, {(32-SW){1'b0}}};
  assign word_r = mute ? '0 : {mono ? src_l : src_r, {(32-SW){1'b0}}};
  always_comb begin
    acc_d    = wrap ? acc_q - MOD + INC : acc_q + INC;
    mclk_d   = mclk_q ^ wrap;
    div_d    = div_q + 2'(mclk_rise);
    slot_d   = slot_q + 5'(sclk_fall);
    lrck_d   = lrck_q ^ slot_end;
    dac_d    = sclk_fall ? shreg_q[31] : dac_q;
    shreg_d  = slot_end ? (lrck_q ? word_l : hold_q)
             : (sclk_fall && int'(slot_q) < SW) ? {shreg_q[30:0], 1'b0} : shreg_q;
    hold_d   = left_load ? word_r : hold_q;
    last_l_d = pop ? mem_l[rp_q] : last_l_q;
    last_r_d = pop ? mem_r[rp_q] : last_r_q;
    uf_d     = (left_load && empty) || (uf_q && !underflow_clr);
    lvl_d    = lvl_q + LW'(push) - LW'(pop);
    rdy_d    = lvl_d < LW'(FIFO_DEPTH);
    wp_d     = wp_q + PW'(push);
    rp_d     = rp_q + PW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mclk_q   <= 1'b0;
      div_q    <= '0;
      slot_q   <= '0;
      lrck_q   <= 1'b0;
      dac_q    <= 1'b0;
      shreg_q  <= '0;
      hold_q   <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      uf_q     <= 1'b0;
      rdy_q    <= 1'b0;
      lvl_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      mclk_q   <= mclk_d;
      div_q    <= div_d;
      slot_q   <= slot_d;
      lrck_q   <= lrck_d;
      dac_q    <= dac_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      uf_q     <= uf_d;
      rdy_q    <= rdy_d;
      lvl_q    <= lvl_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wp_q] <= sample_l;
      mem_r[wp_q] <= sample_r;
    end
  end
  assign sample_ready = rdy_q;
  assign underflow    = uf_q;
  assign fifo_level   = lvl_q;
  assign audio_mclk   = mclk_q;
  assign audio_lrck   = lrck_q;
  assign audio_dac    = dac_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed scoreboard bench; instance 0 sends zeros on underflow, instance 1 repeats
module tb_i2s_audio_tx;
  typedef struct {
    int           f;
    logic [127:0] w;
    string        tag;
  } exp_t;
  logic clk = 0, reset_n = 0;
  logic [15:0] sl = 0, sr = 0;
  logic sv = 0, mono = 0, mute = 0, uclr = 0;
  logic [1:0] rdy, uf, mclk, lrck, dac;
  logic [2:0] lvl [2];
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  logic pm = 0, pl = 0, plr = 0;
  logic [31:0] wl [2];
  logic [31:0] wr [2];
  int nr = 0, sev = 0, fdone = 0, mtog = 0, ltog = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    i2s_audio_tx #(.REPEAT_ON_UNDERFLOW(g)) dut (
      .clk(clk), .reset_n(reset_n), .sample_l(sl), .sample_r(sr), .sample_valid(sv),
      .sample_ready(rdy[g]), .mono(mono), .mute(mute), .underflow_clr(uclr),
      .underflow(uf[g]), .fifo_level(lvl[g]), .audio_mclk(mclk[g]),
      .audio_lrck(lrck[g]), .audio_dac(dac[g])
    );
  end
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic expect_frame(input int f, input string tag, input logic [15:0] l, r, lr, rr);
    exp_t e;
    e.f = f;
    e.tag = tag;
    e.w = {l, 16'h0, r, 16'h0, lr, 16'h0, rr, 16'h0};
    exp_q.push_back(e);
  endtask
  // one clk of monitoring: every 4th MCLK rise is an SCLK fall carrying one serial bit
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      pm = 0; pl = 0; plr = 0; nr = 0;
    end else begin
      if (mclk[0] != pm) mtog++;
      if (lrck[0] != plr) ltog++;
      plr = lrck[0];
      if (mclk[0] && !pm) begin
        nr++;
        if (nr % 4 == 0) begin
          sev++;
          for (int b = 0; b < 2; b++)
            if (pl) wr[b] = {wr[b][30:0], dac[b]};
            else wl[b] = {wl[b][30:0], dac[b]};
          if (pl && !lrck[0]) begin
            fdone++;
            while (exp_q.size() > 0 && exp_q[0].f <= fdone) begin
              e = exp_q.pop_front();
              chk(e.tag, {fdone, wl[0], wr[0], wl[1], wr[1]}, {e.f, e.w});
            end
          end
          pl = lrck[0];
        end
      end
      pm = mclk[0];
    end
  endtask
  task automatic wait_frame();
    int f0 = fdone;
    int n = 0;
    while (fdone == f0 && n < 4000) begin cyc(); n++; end
    chk("frame_seen", fdone != f0, 1);
  endtask
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    sl = l; sr = r; sv = 1;
    while (!rdy[0] && n < 4000) begin cyc(); n++; end
    chk("push_ready", rdy[0], 1);
    cyc();
  endtask
  task automatic pulse_clr();
    uclr = 1;
    cyc();
    uclr = 0;
  endtask
  initial begin
    int n, s0, r, q;
    repeat (3) cyc();
    chk("reset_outputs", {rdy, uf, mclk, lrck, dac, lvl[0], lvl[1]}, 0);
    reset_n = 1; mtog = 0; ltog = 0; sev = 0;
    cyc();
    chk("ready_after_reset", rdy, 2'b11);
    repeat (37124) cyc();
    chk("mclk_toggles", (mtog >= 12287 && mtog <= 12289) ? 12288 : mtog, 12288);
    chk("sclk_toggles", (2 * sev >= 3070 && 2 * sev <= 3074) ? 3072 : 2 * sev, 3072);
    chk("lrck_toggles", (ltog >= 47 && ltog <= 49) ? 48 : ltog, 48);
    chk("underflow_set", uf, 2'b11);
    wait_frame();
    expect_frame(fdone + 1, "underflow_zeros", 0, 0, 0, 0);
    chk("underflow_held", uf, 2'b11);
    pulse_clr();
    chk("underflow_clr", uf, 2'b00);
    wait_frame();
    push(16'h8001, 16'h7FFE);
    sv = 0;
    pulse_clr();
    chk("level_one", {lvl[0], lvl[1]}, {3'd1, 3'd1});
    expect_frame(fdone + 2, "serial", 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE);
    wait_frame();
    chk("level_zero_after_pop", lvl[0], 0);
    chk("no_underflow", uf, 2'b00);
    mono = 1;
    push(16'h1234, 16'hFFFF);
    sv = 0;
    expect_frame(fdone + 2, "mono", 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    wait_frame();
    mono = 0; mute = 1;
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    sv = 0;
    chk("level_two", lvl[0], 2);
    expect_frame(fdone + 2, "mute_a", 0, 0, 0, 0);
    expect_frame(fdone + 3, "mute_b", 0, 0, 0, 0);
    wait_frame();
    chk("mute_level_one", lvl[0], 1);
    wait_frame();
    chk("mute_level_zero", lvl[0], 0);
    mute = 0;
    push(16'h0F0F, 16'hF0F0);
    sv = 0;
    expect_frame(fdone + 2, "repeat_src", 16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0);
    expect_frame(fdone + 3, "repeat_uf", 0, 0, 16'h0F0F, 16'hF0F0);
    wait_frame();
    chk("no_underflow_2", uf, 2'b00);
    wait_frame();
    chk("underflow_repeat", uf, 2'b11);
    q = fdone;
    push(16'hA001, 16'hA002);
    push(16'hB001, 16'hB002);
    push(16'hC001, 16'hC002);
    push(16'hD001, 16'hD002);
    chk("full", {rdy[0], lvl[0]}, {1'b0, 3'd4});
    push(16'hE001, 16'hE002);
    sv = 0;
    chk("refill_level", {rdy[0], lvl[0]}, {1'b0, 3'd4});
    expect_frame(q + 2, "bp_a", 16'hA001, 16'hA002, 16'hA001, 16'hA002);
    expect_frame(q + 3, "bp_b", 16'hB001, 16'hB002, 16'hB001, 16'hB002);
    expect_frame(q + 4, "bp_c", 16'hC001, 16'hC002, 16'hC001, 16'hC002);
    expect_frame(q + 5, "bp_d", 16'hD001, 16'hD002, 16'hD001, 16'hD002);
    expect_frame(q + 6, "bp_e", 16'hE001, 16'hE002, 16'hE001, 16'hE002);
    n = 0;
    while (fdone < q + 6 && n < 10) begin wait_frame(); n++; end
    push(16'hDEAD, 16'hBEEF);
    sv = 0;
    n = 0;
    while (!lrck[0] && n < 4000) begin cyc(); n++; end
    s0 = sev;
    n = 0;
    while (sev < s0 + 10 && n < 4000) begin cyc(); n++; end
    chk("reset_at_right_slot10", {lrck[0], sev - s0}, {1'b1, 32'd10});
    reset_n = 0;
    #1;
    chk("reset_async", {rdy, uf, mclk, lrck, dac, lvl[0], lvl[1]}, 0);
    repeat (3) cyc();
    reset_n = 1;
    s0 = sev;
    r = fdone;
    push(16'h5A5A, 16'hA5A5);
    sv = 0;
    expect_frame(r + 1, "post_reset_idle", 0, 0, 0, 0);
    expect_frame(r + 2, "post_reset", 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5);
    n = 0;
    while (!lrck[0] && n < 4000) begin cyc(); n++; end
    chk("first_lrck_edge", sev - s0, 32);
    n = 0;
    while (fdone < r + 2 && n < 10) begin wait_frame(); n++; end
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
